// File: rtl/rocket_unit.sv
// rocket_unit: single-rocket launcher/mover feeding the pixel renderer.
//
// Ports:
//   clk, reset            system/pixel clock; synchronous active-high reset
//   clk_1ms               one-cycle tick strobe, once per ms (clk domain)
//   fire                  debounced fire button level; launches on rising edge
//   ship_x                ship centre column
//   game_state            00 idle, 01 playing, 10 win, 11 lose
//   hit                   one-cycle strobe: rocket struck an asteroid
//   x, y                  current scan position
//   rocket_on             current pixel lies inside the rocket (combinational)
//   rgb_rocket            constant rocket colour
//   rocket_active         rocket is in flight
//   rocket_x, rocket_y    rocket left/top edge for collision logic
`timescale 1ns/1ps

module rocket_unit #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned SHIP_Y       = 440,
  parameter int unsigned ROCKET_W     = 4,
  parameter int unsigned ROCKET_H     = 12,
  parameter int unsigned STEP         = 4,
  parameter int unsigned COOLDOWN_MS  = 200,
  parameter logic [11:0] ROCKET_COLOR = 12'hF80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_1ms,
  input  logic        fire,
  input  logic [9:0]  ship_x,
  input  logic [1:0]  game_state,
  input  logic        hit,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        rocket_on,
  output logic [11:0] rgb_rocket,
  output logic        rocket_active,
  output logic [9:0]  rocket_x,
  output logic [9:0]  rocket_y
);

  localparam int unsigned CW = (COOLDOWN_MS > 0) ? $clog2(COOLDOWN_MS + 1) : 1;

  localparam logic signed [11:0] HALF_W    = 12'(ROCKET_W / 2);
  localparam logic signed [11:0] MAX_X     = 12'(H_ACTIVE - ROCKET_W);
  localparam logic [9:0]         SPAWN_Y   = 10'(SHIP_Y - ROCKET_H);
  localparam logic [9:0]         STEP_V    = 10'(STEP);
  localparam logic [CW-1:0]      COOL_INIT = CW'(COOLDOWN_MS);
  localparam logic [10:0]        W_EXT     = 11'(ROCKET_W);
  localparam logic [10:0]        H_EXT     = 11'(ROCKET_H);

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    COOLDOWN
  } state_t;

  state_t          state_q;
  logic            fire_q;
  logic [9:0]      rx_q;
  logic [9:0]      ry_q;
  logic [CW-1:0]   cnt_q;

  logic            fire_rise;
  logic            playing;
  logic signed [11:0] spawn_s;
  logic [9:0]      spawn_x;
  logic [10:0]     xe, ye, rxe, rye;
  logic            in_x, in_y;

  assign fire_rise = fire & ~fire_q;
  assign playing   = (game_state == 2'b01);

  // Spawn column is centred on the ship, clamped so the whole rocket is on
  // screen; signed arithmetic so a ship near column 0 clamps instead of wrapping.
  always_comb begin
    spawn_s = $signed({2'b00, ship_x}) - HALF_W;
    if (spawn_s < 12'sd0) begin
      spawn_x = '0;
    end else if (spawn_s > MAX_X) begin
      spawn_x = MAX_X[9:0];
    end else begin
      spawn_x = spawn_s[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fire_q  <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      cnt_q   <= '0;
    end else begin
      fire_q <= fire;
      unique case (state_q)
        IDLE: begin
          if (fire_rise && playing) begin
            state_q <= FLIGHT;
            rx_q    <= spawn_x;
            ry_q    <= SPAWN_Y;
          end
        end
        FLIGHT: begin
          if (!playing) begin
            state_q <= IDLE;
          end else if (hit) begin
            state_q <= COOLDOWN;
            cnt_q   <= COOL_INIT;
          end else if (clk_1ms) begin
            // Retire rather than step when the next move would go above row 0.
            if (ry_q < STEP_V) begin
              state_q <= COOLDOWN;
              cnt_q   <= COOL_INIT;
            end else begin
              ry_q <= ry_q - STEP_V;
            end
          end
        end
        COOLDOWN: begin
          if (!playing || (cnt_q == '0)) begin
            state_q <= IDLE;
          end else if (clk_1ms) begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // 11-bit compares so rocket_x + ROCKET_W cannot overflow at the right edge.
  assign xe   = {1'b0, x};
  assign ye   = {1'b0, y};
  assign rxe  = {1'b0, rx_q};
  assign rye  = {1'b0, ry_q};
  assign in_x = (xe >= rxe) && (xe < rxe + W_EXT);
  assign in_y = (ye >= rye) && (ye < rye + H_EXT);

  assign rocket_active = (state_q == FLIGHT);
  assign rocket_on     = rocket_active && in_x && in_y;
  assign rgb_rocket    = ROCKET_COLOR;
  assign rocket_x      = rx_q;
  assign rocket_y      = ry_q;

endmodule

// File: tb/tb_rocket_unit.sv
`timescale 1ns/1ps

module tb_rocket_unit;

  logic        clk = 1'b0;
  logic        reset, clk_1ms, fire, hit;
  logic [9:0]  ship_x, x, y;
  logic [1:0]  game_state;
  logic        rocket_on, rocket_active;
  logic [11:0] rgb_rocket;
  logic [9:0]  rocket_x, rocket_y;

  int n_cmp = 0;
  int n_err = 0;
  logic bad;

  always #5 clk = ~clk;

  rocket_unit #(
    .H_ACTIVE    (640),
    .SHIP_Y      (440),
    .ROCKET_W    (4),
    .ROCKET_H    (12),
    .STEP        (4),
    .COOLDOWN_MS (200),
    .ROCKET_COLOR(12'hF80)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_1ms      (clk_1ms),
    .fire         (fire),
    .ship_x       (ship_x),
    .game_state   (game_state),
    .hit          (hit),
    .x            (x),
    .y            (y),
    .rocket_on    (rocket_on),
    .rgb_rocket   (rgb_rocket),
    .rocket_active(rocket_active),
    .rocket_x     (rocket_x),
    .rocket_y     (rocket_y)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    clk_1ms = 1'b1;
    step();
    clk_1ms = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clk_1ms = 1'b0; fire = 1'b0; hit = 1'b0;
    ship_x = 10'd320; x = '0; y = '0; game_state = 2'b00;

    // reset state
    step();
    chk("rgb_in_reset", 32'(rgb_rocket), 32'hF80);
    step();
    reset = 1'b0; game_state = 2'b01;
    #1;
    chk("rst_active", 32'(rocket_active), 0);
    chk("rst_on", 32'(rocket_on), 0);
    chk("rst_x", 32'(rocket_x), 0);
    chk("rst_y", 32'(rocket_y), 0);
    chk("rst_cnt", 32'(dut.cnt_q), 0);
    chk("rst_rgb", 32'(rgb_rocket), 32'hF80);

    // launch from ship_x=320
    fire = 1'b1;
    step();
    chk("launch_active", 32'(rocket_active), 1);
    chk("launch_x", 32'(rocket_x), 318);
    chk("launch_y", 32'(rocket_y), 428);
    x = 10'd318; y = 10'd428; #1 chk("on_topleft", 32'(rocket_on), 1);
    x = 10'd321; y = 10'd439; #1 chk("on_botright", 32'(rocket_on), 1);
    x = 10'd322; y = 10'd428; #1 chk("on_right_out", 32'(rocket_on), 0);
    x = 10'd318; y = 10'd440; #1 chk("on_below_out", 32'(rocket_on), 0);

    // fly to the top with fire held
    tick();
    chk("y_tick1", 32'(rocket_y), 424);
    for (int i = 0; i < 106; i++) tick();
    chk("y_at_top", 32'(rocket_y), 0);
    chk("active_at_top", 32'(rocket_active), 1);
    tick();
    chk("offtop_active", 32'(rocket_active), 0);
    chk("offtop_y", 32'(rocket_y), 0);
    chk("offtop_cnt", 32'(dut.cnt_q), 200);
    for (int i = 0; i < 199; i++) tick();
    chk("cool_cnt_1", 32'(dut.cnt_q), 1);
    chk("held_no_relaunch", 32'(rocket_active), 0);
    fire = 1'b0; step();
    fire = 1'b1; step();
    fire = 1'b0;
    chk("fire_in_cool", 32'(rocket_active), 0);
    tick();
    chk("cool_cnt_0", 32'(dut.cnt_q), 0);
    fire = 1'b1; step();
    chk("fire_on_exit", 32'(rocket_active), 0);
    step();
    chk("held_after_exit", 32'(rocket_active), 0);
    fire = 1'b0; step();
    fire = 1'b1; step();
    chk("relaunch", 32'(rocket_active), 1);
    chk("relaunch_y", 32'(rocket_y), 428);

    // hit together with a tick
    tick();
    chk("y_before_hit", 32'(rocket_y), 424);
    hit = 1'b1; clk_1ms = 1'b1;
    step();
    hit = 1'b0; clk_1ms = 1'b0;
    chk("hit_active", 32'(rocket_active), 0);
    chk("hit_y", 32'(rocket_y), 424);
    chk("hit_cnt", 32'(dut.cnt_q), 200);
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      fire = ((i % 2) == 1);
      tick();
      if (rocket_active !== 1'b0) bad = 1'b1;
    end
    chk("cool_fire_ignored", 32'(bad), 0);
    chk("hit_cool_done", 32'(dut.cnt_q), 0);
    fire = 1'b0; step();
    fire = 1'b1; step();
    chk("relaunch2", 32'(rocket_active), 1);

    // clamp at the left edge
    game_state = 2'b00; step();
    chk("gs0_leaves_flight", 32'(rocket_active), 0);
    fire = 1'b0; ship_x = 10'd1; game_state = 2'b01; step();
    fire = 1'b1; step();
    chk("clamp_lo_active", 32'(rocket_active), 1);
    chk("clamp_lo_x", 32'(rocket_x), 0);
    x = 10'd0; y = 10'd428; #1 chk("clamp_lo_on0", 32'(rocket_on), 1);
    x = 10'd4; #1 chk("clamp_lo_on4", 32'(rocket_on), 0);

    // clamp at the right edge
    game_state = 2'b00; step();
    game_state = 2'b01; ship_x = 10'd639; fire = 1'b0; step();
    fire = 1'b1; step();
    chk("clamp_hi_x", 32'(rocket_x), 636);
    x = 10'd639; y = 10'd430; #1 chk("clamp_hi_on639", 32'(rocket_on), 1);
    x = 10'd0; #1 chk("clamp_hi_on0", 32'(rocket_on), 0);

    // lose mid-flight
    game_state = 2'b11; step();
    chk("lose_active", 32'(rocket_active), 0);
    chk("lose_x_hold", 32'(rocket_x), 636);
    chk("lose_y_hold", 32'(rocket_y), 428);
    x = 10'd639; y = 10'd430; #1 chk("lose_on", 32'(rocket_on), 0);
    fire = 1'b0; game_state = 2'b00; step();
    fire = 1'b1; step();
    chk("gs0_no_launch", 32'(rocket_active), 0);

    // reset during flight
    game_state = 2'b01; fire = 1'b0; step();
    fire = 1'b1; step();
    chk("pre_rst_fl_active", 32'(rocket_active), 1);
    fire = 1'b0; reset = 1'b1; x = '0; y = '0;
    step();
    chk("rst_fl_active", 32'(rocket_active), 0);
    chk("rst_fl_x", 32'(rocket_x), 0);
    chk("rst_fl_y", 32'(rocket_y), 0);
    chk("rst_fl_cnt", 32'(dut.cnt_q), 0);
    chk("rst_fl_on", 32'(rocket_on), 0);
    chk("rst_fl_rgb", 32'(rgb_rocket), 32'hF80);
    reset = 1'b0;

    // reset during cooldown
    step();
    fire = 1'b1; step();
    chk("pre_rst_cd_active", 32'(rocket_active), 1);
    hit = 1'b1; step();
    hit = 1'b0;
    chk("pre_rst_cd_cnt", 32'(dut.cnt_q), 200);
    fire = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_cd_active", 32'(rocket_active), 0);
    chk("rst_cd_x", 32'(rocket_x), 0);
    chk("rst_cd_y", 32'(rocket_y), 0);
    chk("rst_cd_cnt", 32'(dut.cnt_q), 0);
    chk("rst_cd_rgb", 32'(rgb_rocket), 32'hF80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
